cla_pipe_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder. Successor to the fixed 13-bit

---
 rtl/cla_pipe_adder.sv | 231 +++++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//   Parametrised, pipelined carry-lookahead adder. Adds two WIDTH-bit unsigned
//   operands plus a carry-in and produces {carry_out, sum} with the signed
//   overflow flag of the WIDTH-bit sum. Operands are split into GROUP-bit
//   lookahead groups; the inter-group carry chain is spread over STAGES
//   register stages, and each stage resolves a contiguous run of groups.
//   A valid/ready handshake sits on both ends. The pipe has no skid buffer,
//   so o_ready is combinational from i_ready.
//
// Parameters
//   WIDTH   operand width in bits (>= 2)
//   GROUP   bits per lookahead group (last group may be partial)
//   STAGES  register stages, 1..ceil(WIDTH/GROUP); equals latency in cycles
//
// Optional feature
//   CLA_SUB_EN  when defined, adds i_sub. With i_sub=1 the B operand is
//               inverted and the carry-in is inverted: A + ~B + ~i_cin.
//
// Ports
//   i_clk     in   clock, rising edge
//   i_rst_n   in   asynchronous active-low reset
//   i_valid   in   operand beat valid
//   o_ready   out  adder can accept a beat this cycle
//   i_add1    in   operand A [WIDTH-1:0]
//   i_add2    in   operand B [WIDTH-1:0]
//   i_cin     in   carry-in
//   i_sub     in   subtract select (CLA_SUB_EN only)
//   o_valid   out  result beat valid
//   i_ready   in   downstream accepts result
//   o_result  out  {carry_out, sum} [WIDTH:0]
//   o_ovf     out  signed overflow of the WIDTH-bit sum
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH  = 13,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
`ifdef CLA_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int NGRP  = (WIDTH + GROUP - 1) / GROUP;
  localparam int LAST  = STAGES - 1;
  // Operand registers only exist between stages; keep at least one entry so
  // the array stays legal for a single-stage build.
  localparam int NOPS  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int GBASE = NGRP / STAGES;
  localparam int GREM  = NGRP % STAGES;

  // First group owned by stage k. Groups are split evenly and the earliest
  // stages each take one extra group until the remainder is used up, so
  // grp_lo(STAGES) == NGRP.
  function automatic int grp_lo(input int k);
    return k * GBASE + ((k < GREM) ? k : GREM);
  endfunction

  // Per-stage state: valid bit, partial sum, carry into the next unresolved
  // group, and the carry into the MSB (needed for the overflow flag).
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] m_q;
  logic [WIDTH-1:0]  a_q [NOPS];
  logic [WIDTH-1:0]  b_q [NOPS];

  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  b0;
  logic              c0;

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] in_v;
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic [STAGES-1:0] c_nx;
  logic [STAGES-1:0] m_nx;

  // Subtraction is folded into the operands before the first stage, so the
  // rest of the pipe only ever adds. i_sub is therefore captured together
  // with the operands at input transfer.
  always_comb begin
    a0 = i_add1;
`ifdef CLA_SUB_EN
    b0 = i_sub ? ~i_add2 : i_add2;
    c0 = i_cin ^ i_sub;
`else
    b0 = i_add2;
    c0 = i_cin;
`endif
  end

  // Handshake chain, resolved from the output end backwards. A stage can
  // load when it is empty or when its current contents move on this cycle;
  // ~v | (v & next_ready) reduces to ~v | next_ready.
  always_comb begin
    rdy  = '0;
    in_v = '0;
    for (int k = LAST; k >= 0; k--) begin
      if (k == LAST) rdy[k] = ~v_q[k] | i_ready;
      else           rdy[k] = ~v_q[k] | rdy[(k < LAST) ? k + 1 : LAST];
      in_v[k] = (k == 0) ? i_valid : v_q[(k > 0) ? k - 1 : 0];
    end
  end

  // Datapath. For each stage: bit generate/propagate, group G/P by
  // lookahead, carries across the stage's groups from group G/P, then the
  // sum bits of those groups from each group's carry-in. Bits owned by other
  // stages pass through unchanged.
  always_comb begin : p_sum
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prp;
    logic [WIDTH-1:0] sum;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_c;
    logic             carry;
    logic             cb;
    logic             msb;
    int               lo;
    int               hi;

    c_nx = '0;
    m_nx = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
      s_nx[k] = '0;
    end

    for (int k = 0; k < STAGES; k++) begin
      lo = grp_lo(k);
      hi = grp_lo(k + 1);

      if (k == 0) begin
        a_in[k] = a0;
        b_in[k] = b0;
        sum     = '0;
        carry   = c0;
        msb     = 1'b0;
      end else begin
        a_in[k] = a_q[k - 1];
        b_in[k] = b_q[k - 1];
        sum     = s_q[k - 1];
        carry   = c_q[k - 1];
        msb     = m_q[k - 1];
      end

      gen   = a_in[k] & b_in[k];
      prp   = a_in[k] ^ b_in[k];
      grp_g = '0;
      grp_p = '1;
      for (int i = 0; i < WIDTH; i++) begin
        grp_g[i / GROUP] = gen[i] | (prp[i] & grp_g[i / GROUP]);
        grp_p[i / GROUP] = prp[i] & grp_p[i / GROUP];
      end

      grp_c = '0;
      for (int g = 0; g < NGRP; g++) begin
        if (g >= lo && g < hi) begin
          grp_c[g] = carry;
          carry    = grp_g[g] | (grp_p[g] & carry);
        end
      end

      cb = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if ((i / GROUP) >= lo && (i / GROUP) < hi) begin
          if ((i % GROUP) == 0) cb = grp_c[i / GROUP];
          sum[i] = prp[i] ^ cb;
          if (i == WIDTH - 1) msb = cb;
          cb = gen[i] | (prp[i] & cb);
        end
      end

      s_nx[k] = sum;
      c_nx[k] = carry;
      m_nx[k] = msb;
    end
  end

  // Stage registers. Data only loads alongside a real beat, so an empty
  // stage keeps its old contents and o_result holds its last value when the
  // pipe drains.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q <= '0;
      c_q <= '0;
      m_q <= '0;
      for (int k = 0; k < STAGES; k++) s_q[k] <= '0;
      for (int j = 0; j < NOPS; j++) begin
        a_q[j] <= '0;
        b_q[j] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) v_q[k] <= in_v[k];
        if (rdy[k] && in_v[k]) begin
          s_q[k] <= s_nx[k];
          c_q[k] <= c_nx[k];
          m_q[k] <= m_nx[k];
        end
      end
      for (int j = 0; j < NOPS; j++) begin
        if (STAGES > 1 && rdy[j] && in_v[j]) begin
          a_q[j] <= a_in[j];
          b_q[j] <= b_in[j];
        end
      end
    end
  end

  assign o_ready  = rdy[0];
  assign o_valid  = v_q[LAST];
  assign o_result = {c_q[LAST], s_q[LAST]};
  // Overflow is the carry out of the MSB disagreeing with the carry into it.
  assign o_ovf    = c_q[LAST] ^ m_q[LAST];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=13, GROUP=4, STAGES=2).
//   Expected results come from a plain-arithmetic reference model; a second
//   set of instances with STAGES=1,3,4 is used for the latency sweep.
//   Inputs are driven 1 ns after the rising edge; transfers are recorded at
//   the falling edge, where inputs and outputs are stable.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

  localparam int WIDTH  = 13;
  localparam int GROUP  = 4;
  localparam int STAGES = 2;
`ifdef CLA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_add1;
  logic [WIDTH-1:0] i_add2;
  logic             i_cin;
  logic             i_sub;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH:0]   o_result;
  logic             o_ovf;

  logic             sw_valid;
  logic [2:0]       sw_ordy;
  logic [2:0]       sw_ovalid;
  logic [WIDTH:0]   sw_res [3];
  logic [2:0]       sw_ovf;

  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] obs_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_add1   (i_add1),
    .i_add2   (i_add2),
    .i_cin    (i_cin),
`ifdef CLA_SUB_EN
    .i_sub    (i_sub),
`endif
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovf    (o_ovf)
  );

  // Latency-sweep instances share operands and reset, with their own valid.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int SW = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(SW)) sw_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (sw_valid),
      .o_ready  (sw_ordy[gi]),
      .i_add1   (i_add1),
      .i_add2   (i_add2),
      .i_cin    (i_cin),
`ifdef CLA_SUB_EN
      .i_sub    (i_sub),
`endif
      .o_valid  (sw_ovalid[gi]),
      .i_ready  (1'b1),
      .o_result (sw_res[gi]),
      .o_ovf    (sw_ovf[gi])
    );
  end

  // Reference: {ovf, carry, sum} from plain integer addition.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [31:0]      total;
    logic [WIDTH:0]   r;
    logic             ov;
    bb = b;
    cc = cin;
    if (SUB_EN && sub) begin
      bb = ~b;
      cc = ~cin;
    end
    total = 32'(a) + 32'(bb) + 32'(cc);
    r     = total[WIDTH:0];
    ov    = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return {ov, r};
  endfunction

  // One clock: record this cycle's transfers, then step past the edge.
  task automatic tick();
    @(negedge clk);
    if (i_valid && o_ready) exp_q.push_back(model(i_add1, i_add2, i_cin, i_sub));
    if (o_valid && i_ready) obs_q.push_back({o_ovf, o_result});
    @(posedge clk);
    #1;
  endtask

  // Send a single beat into an empty pipe and wait for its result.
  task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub,
                          output int lat, output logic [WIDTH:0] res,
                          output logic ovf);
    exp_q.delete();
    obs_q.delete();
    i_ready = 1'b1;
    i_add1  = a;
    i_add2  = b;
    i_cin   = cin;
    i_sub   = sub;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (o_valid !== 1'b1) lat = -1;
    res = o_result;
    ovf = o_ovf;
    tick();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_add1   = '0;
    i_add2   = '0;
    i_cin    = 1'b0;
    i_sub    = 1'b0;
    sw_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_valid: got %b want 0", o_valid);
    end
    n_checks++;
    if (o_result !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_result: got %h want 0", o_result);
    end
    n_checks++;
    if (o_ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ovf: got %b want 0", o_ovf);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b want 1", o_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_carry_out();
    int             lat;
    logic [WIDTH:0] res;
    logic           ovf;
    send_one(13'h1FFF, 13'h0001, 1'b0, 1'b0, lat, res, ovf);
    n_checks++;
    if (lat != STAGES) begin
      n_fail++;
      $display("[TB] FAIL carry_latency: got %0d want %0d", lat, STAGES);
    end
    n_checks++;
    if (res !== 14'h2000) begin
      n_fail++;
      $display("[TB] FAIL carry_result: got %h want 2000", res);
    end
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL carry_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_overflow();
    int             lat;
    logic [WIDTH:0] res;
    logic           ovf;
    send_one(13'h0FFF, 13'h0001, 1'b1, 1'b0, lat, res, ovf);
    n_checks++;
    if (res !== 14'h1001) begin
      n_fail++;
      $display("[TB] FAIL ovf_result: got %h want 1001", res);
    end
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovf_flag: got %b want 1", ovf);
    end
  endtask

  task automatic test_back_to_back();
    int ticks = 0;
    int drops = 0;
    exp_q.delete();
    obs_q.delete();
    i_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      i_add1  = WIDTH'($urandom);
      i_add2  = WIDTH'($urandom);
      i_cin   = 1'($urandom);
      i_sub   = 1'($urandom);
      i_valid = 1'b1;
      if (o_ready !== 1'b1) drops++;
      tick();
      ticks++;
    end
    i_valid = 1'b0;
    while (obs_q.size() < 100 && ticks < 400) begin
      tick();
      ticks++;
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_ready: got %0d stalls want 0", drops);
    end
    n_checks++;
    if (obs_q.size() != 100 || exp_q.size() != 100) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d results %0d beats want 100",
               obs_q.size(), exp_q.size());
    end
    n_checks++;
    if (ticks != 100 + STAGES) begin
      n_fail++;
      $display("[TB] FAIL b2b_throughput: got %0d cycles want %0d", ticks, 100 + STAGES);
    end
    for (int n = 0; n < obs_q.size() && n < exp_q.size(); n++) begin
      n_checks++;
      if (obs_q[n] !== exp_q[n]) begin
        n_fail++;
        $display("[TB] FAIL b2b_beat%0d: got %h want %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_stall();
    int             cyc = 0;
    logic [WIDTH:0] hold_res;
    logic           hold_ovf;
    exp_q.delete();
    obs_q.delete();
    i_ready = 1'b0;
    i_valid = 1'b1;
    while (o_ready === 1'b1 && cyc < 20) begin
      i_add1 = WIDTH'($urandom);
      i_add2 = WIDTH'($urandom);
      i_cin  = 1'($urandom);
      i_sub  = 1'($urandom);
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != STAGES) begin
      n_fail++;
      $display("[TB] FAIL stall_fill: got %0d beats want %0d", exp_q.size(), STAGES);
    end
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_valid: got %b want 1", o_valid);
    end
    hold_res = o_result;
    hold_ovf = o_ovf;
    n_checks++;
    if (exp_q.size() > 0 && {hold_ovf, hold_res} !== exp_q[0]) begin
      n_fail++;
      $display("[TB] FAIL stall_head: got %h want %h", {hold_ovf, hold_res}, exp_q[0]);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++;
      if ({o_ovf, o_result} !== {hold_ovf, hold_res} || o_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold%0d: got %h ready %b want %h ready 0",
                 n, {o_ovf, o_result}, o_ready, {hold_ovf, hold_res});
      end
    end
    n_checks++;
    if (exp_q.size() != STAGES) begin
      n_fail++;
      $display("[TB] FAIL stall_accept: got %0d beats want %0d", exp_q.size(), STAGES);
    end
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_release_ready: got %b want 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (obs_q.size() != STAGES + 1 || exp_q.size() != STAGES + 1) begin
      n_fail++;
      $display("[TB] FAIL stall_drain: got %0d results %0d beats want %0d",
               obs_q.size(), exp_q.size(), STAGES + 1);
    end
    for (int n = 0; n < obs_q.size() && n < exp_q.size(); n++) begin
      n_checks++;
      if (obs_q[n] !== exp_q[n]) begin
        n_fail++;
        $display("[TB] FAIL stall_beat%0d: got %h want %h", n, obs_q[n], exp_q[n]);
      end
    end
  endtask

`ifdef CLA_SUB_EN
  task automatic test_sub();
    int             lat;
    logic [WIDTH:0] res;
    logic           ovf;
    send_one(13'd5, 13'd7, 1'b0, 1'b1, lat, res, ovf);
    n_checks++;
    if (res !== 14'h1FFE || ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sub_basic: got %h ovf %b want 1ffe ovf 0", res, ovf);
    end
    send_one(13'h1000, 13'h0001, 1'b0, 1'b1, lat, res, ovf);
    n_checks++;
    if (res !== 14'h2FFF || ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sub_ovf: got %h ovf %b want 2fff ovf 1", res, ovf);
    end
  endtask
`endif

  task automatic test_latency_sweep();
    int               lat [3];
    logic [WIDTH+1:0] got [3];
    logic [WIDTH+1:0] want;
    int               sw_stages [3];
    sw_stages = '{1, 3, 4};
    i_ready = 1'b1;
    i_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        i_add1 = 13'h1FFF;
        i_add2 = 13'h0001;
        i_cin  = 1'b0;
        i_sub  = 1'b0;
      end else begin
        i_add1 = WIDTH'($urandom);
        i_add2 = WIDTH'($urandom);
        i_cin  = 1'($urandom);
        i_sub  = 1'($urandom);
      end
      want = model(i_add1, i_add2, i_cin, i_sub);
      for (int i = 0; i < 3; i++) begin
        lat[i] = -1;
        got[i] = '0;
      end
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        for (int i = 0; i < 3; i++) begin
          if (lat[i] < 0 && sw_ovalid[i] === 1'b1) begin
            lat[i] = c;
            got[i] = {sw_ovf[i], sw_res[i]};
          end
        end
        tick();
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (lat[i] != sw_stages[i] || got[i] !== want) begin
          n_fail++;
          $display("[TB] FAIL sweep_s%0d_t%0d: got lat %0d val %h want lat %0d val %h",
                   sw_stages[i], t, lat[i], got[i], sw_stages[i], want);
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    exp_q.delete();
    obs_q.delete();
    i_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      i_add1  = WIDTH'($urandom);
      i_add2  = WIDTH'($urandom);
      i_cin   = 1'($urandom);
      i_sub   = 1'($urandom);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_inflight: got %b want 1", o_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_result !== '0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_clear: got valid %b result %h ovf %b want 0 0 0",
               o_valid, o_result, o_ovf);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_ready: got %b want 1", o_ready);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      if (o_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL midrst_stale: got %0d valid cycles %0d results want 0",
               seen, obs_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] cla_pipe_adder bench start");
    test_reset();
    test_carry_out();
    test_overflow();
    test_back_to_back();
    test_stall();
`ifdef CLA_SUB_EN
    test_sub();
`endif
    test_latency_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
